seg_bcd_formatter: RTL and testbench
====================================

# seg_bcd_formatter

Sequential binary-to-BCD formatter that sits directly upstream of the seven-segment scan driver and produces its 32-bit packed-digit word and display mode. It accepts a binary value or a character code over a valid/ready handshake. Numbers are converted with an iterative shift-and-add-3 (double-dabble) engine and presented as eight 4-bit decimal digits; characters pass straight through. The outputs are registered and held until the next accepted request, so the scan driver always sees a stable word.

## Interface
- `VALUE_W`, 27: binary input width; 99_999_999 < 2^27.
- `MAX_VALUE`, 99_999_999: largest displayable value; anything above is treated as overflow.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, synchronous, active-high; one clock domain only.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept; high only in IDLE.
- `in_char` in 1: 1 = character request (code in `in_value[3:0]`), 0 = numeric.
- `in_value` in VALUE_W: unsigned binary value, or character code.
- `seg_data_o` out 32: packed digits, digit 0 in [3:0] (rightmost), digit 7 in [31:28].
- `seg_mode_o` out 2: 0 = numeric, 1 = character.
- `done_o` out 1: one-cycle pulse in the first cycle new outputs are visible.

## Operation
- A transfer occurs on a rising edge where `in_valid && in_ready`. Inputs are sampled at that edge only.
- The FSM has three states: IDLE, CONV, FIN.
- **IDLE, character request:** `seg_data_o` <= {28'h0, `in_value[3:0]`} and `seg_mode_o` <= 1 at the acceptance edge. `done_o` pulses. The FSM stays in IDLE.
- **IDLE, numeric request with `in_value` > MAX_VALUE:** `seg_data_o` <= 32'hEEEE_EEEE ("EEEEEEEE") and `seg_mode_o` <= 0 at the acceptance edge. `done_o` pulses. The FSM stays in IDLE.
- **IDLE, numeric request in range:** load the binary shift register, clear the 32-bit BCD accumulator, clear the iteration counter, and go to CONV.
- **CONV:** one iteration per cycle. Every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1. After VALUE_W (27) iterations, go to FIN. The counter is 5 bits and saturates at the terminal value; it does not wrap.
- **FIN:** apply blanking (see Configuration), then `seg_data_o` <= result, `seg_mode_o` <= 0, and `done_o` pulses. Go to IDLE.
- `in_valid` while `in_ready` = 0 is ignored and not queued. The requester must hold the request until it sees ready.
- The driver decodes digit 4'hF as blank and 4'hE as "E". This block never emits a digit value of A–D in numeric mode.
- Reset at any time aborts a conversion with no `done_o`, and all outputs go to their reset values at that edge.

## Timing
- Reset values:
  - `seg_data_o` = 32'hFFFF_FFFF (all blank)
  - `seg_mode_o` = 0
  - `done_o` = 0
  - `in_ready` = 1
  - FSM = IDLE
- Character and overflow requests: latency 1. Outputs change at the acceptance edge and `in_ready` stays high, so back-to-back transfers run one per cycle.
- In-range numeric requests:
  - acceptance edge E0
  - shifts at E1..E27
  - outputs and the `done_o` pulse are registered at E28
  - `in_ready` is low from after E0 until E28, and high again in the cycle after E28
  - throughput is one numeric request per 29 cycles
- `done_o` is high for exactly one cycle per completed request. It is never asserted for an aborted one.

## Configuration
- The macro is `SEG_BCD_LZB_EN` (leading-zero blanking).
- **Defined:** in FIN, digits 7 down to 1 that are 0 and above the most-significant non-zero digit become 4'hF. Digit 0 is never blanked. For example, 0 gives 32'hFFFF_FFF0 and 305 gives 32'hFFFF_F305.
- **Undefined:** all eight digits are shown, with zero padding (305 gives 32'h0000_0305).
- Character and overflow outputs are identical in both builds.

## Structure
- Shared package `seg_pkg` holds:
  - `SEG_MODE_NUM` = 2'd0 and `SEG_MODE_CHAR` = 2'd1
  - digit codes `DIG_BLANK` = 4'hF and `DIG_ERR` = 4'hE
  - `MAX_VALUE`
  - the FSM state enum
- One sub-module, `bcd_add3`: 4-bit combinational nibble correction (n >= 5 ? n+3 : n), instantiated 8 times inside the CONV datapath.

## Test plan
- Reset, then idle: `seg_data_o` = 32'hFFFF_FFFF, `seg_mode_o` = 0, `in_ready` = 1, `done_o` = 0.
- Numeric 12_345_678: 32'h1234_5678 and a `done_o` pulse exactly 28 edges after acceptance. Same check for 99_999_999 → 32'h9999_9999.
- Numeric 0 and 305:
  - with `SEG_BCD_LZB_EN`: 32'hFFFF_FFF0 and 32'hFFFF_F305
  - without it: 32'h0000_0000 and 32'h0000_0305
- Numeric 100_000_000 gives 32'hEEEE_EEEE with mode 0 at the acceptance edge. Character code 3 on the next cycle gives 32'h0000_0003 with mode 1, one cycle later.
- Request 42 and hold `in_valid` with a different value during CONV: the busy-period value is ignored, the result is 32'hFFFF_FF42 (LZB build), and a single `done_o` pulse occurs.
- Accept 87_654_321, assert `rst` at E10: outputs go to reset values at that edge, no `done_o`. A following request 7 completes normally.

Source files
------------

// File: rtl/seg_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : seg_pkg                                                           |
// | Shared constants, FSM state type and blanking helper for seg_bcd_formatter |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

  localparam logic [1:0]  SEG_MODE_NUM  = 2'd0;
  localparam logic [1:0]  SEG_MODE_CHAR = 2'd1;
  localparam logic [3:0]  DIG_BLANK     = 4'hF;
  localparam logic [3:0]  DIG_ERR       = 4'hE;
  localparam int unsigned MAX_VALUE     = 99_999_999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Replace zero digits above the most-significant non-zero digit; digit 0 always shows.
  function automatic logic [31:0] blank_leading(input logic [31:0] d);
    logic [31:0] r;
    logic        lead;
    r    = d;
    lead = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (lead && (d[4*i +: 4] == 4'h0)) begin
        r[4*i +: 4] = DIG_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// +----------------------------------------------------------------------------+
// | Module : bcd_add3                                                          |
// | Double-dabble nibble correction: adds 3 to any digit of 5 or more          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

`default_nettype wire

// File: rtl/seg_bcd_formatter.sv
// +----------------------------------------------------------------------------+
// | Module : seg_bcd_formatter                                                 |
// | Binary/char to packed 8-digit BCD word for the seven-segment scan driver.  |
// | Build option: SEG_BCD_LZB_EN enables leading-zero blanking.                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_bcd_formatter
  import seg_pkg::*;
#(
  parameter int VALUE_W = 27
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_char,
  input  logic [VALUE_W-1:0] in_value,
  output logic [31:0]        seg_data_o,
  output logic [1:0]         seg_mode_o,
  output logic               done_o
);

  localparam logic [VALUE_W-1:0] C_MAX  = VALUE_W'(MAX_VALUE);
  localparam logic [4:0]         C_LAST = 5'(VALUE_W - 1);
  localparam logic [4:0]         C_TERM = 5'(VALUE_W);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [VALUE_W-1:0]   r_bin;
  logic [31:0]          r_bcd;
  logic [4:0]           r_cnt;
  logic [31:0]          r_seg_data;
  logic [1:0]           r_seg_mode;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_ovf;
  logic                 w_do_char;
  logic                 w_do_ovf;
  logic                 w_do_load;
  logic                 w_do_shift;
  logic                 w_do_fin;
  logic [31:0]          w_adj;
  logic [31:0]          w_result;

  assign in_ready   = (r_state == ST_IDLE);
  assign seg_data_o = r_seg_data;
  assign seg_mode_o = r_seg_mode;
  assign done_o     = r_done;

  assign w_accept = in_valid && in_ready;
  assign w_ovf    = (in_value > C_MAX);

  generate
    for (genvar g = 0; g < 8; g++) begin : g_add3
      bcd_add3 u_add3 (
        .i_nib (r_bcd[4*g +: 4]),
        .o_nib (w_adj[4*g +: 4])
      );
    end
  endgenerate

`ifdef SEG_BCD_LZB_EN
  assign w_result = blank_leading(r_bcd);
`else
  assign w_result = r_bcd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_char   = 1'b0;
    w_do_ovf    = 1'b0;
    w_do_load   = 1'b0;
    w_do_shift  = 1'b0;
    w_do_fin    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (in_char) begin
            w_do_char = 1'b1;
          end else if (w_ovf) begin
            w_do_ovf = 1'b1;
          end else begin
            w_do_load   = 1'b1;
            w_state_nxt = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        w_do_shift = 1'b1;
        if (r_cnt >= C_LAST) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        w_do_fin    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_seg_data <= {8{DIG_BLANK}};
      r_seg_mode <= SEG_MODE_NUM;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_do_char) begin
        r_seg_data <= {28'h0, in_value[3:0]};
        r_seg_mode <= SEG_MODE_CHAR;
        r_done     <= 1'b1;
      end
      if (w_do_ovf) begin
        r_seg_data <= {8{DIG_ERR}};
        r_seg_mode <= SEG_MODE_NUM;
        r_done     <= 1'b1;
      end
      if (w_do_load) begin
        r_bin <= in_value;
        r_bcd <= '0;
        r_cnt <= '0;
      end
      if (w_do_shift) begin
        r_bcd <= {w_adj[30:0], r_bin[VALUE_W-1]};
        r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
        if (r_cnt != C_TERM) begin
          r_cnt <= r_cnt + 5'd1;
        end
      end
      if (w_do_fin) begin
        r_seg_data <= w_result;
        r_seg_mode <= SEG_MODE_NUM;
        r_done     <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_bcd_formatter.sv
// +----------------------------------------------------------------------------+
// | Module : tb_seg_bcd_formatter                                              |
// | Directed vector bench for seg_bcd_formatter (both blanking builds)         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seg_bcd_formatter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_char;
  logic [26:0] in_value;
  logic [31:0] seg_data_o;
  logic [1:0]  seg_mode_o;
  logic        done_o;

  int n_cmp = 0;
  int n_bad = 0;

  seg_bcd_formatter #(.VALUE_W(27)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_value   (in_value),
    .seg_data_o (seg_data_o),
    .seg_mode_o (seg_mode_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_char;
    logic [26:0] val;
    logic [31:0] exp_data;
    logic [1:0]  exp_mode;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

`ifdef SEG_BCD_LZB_EN
  localparam logic [31:0] E_ZERO = 32'hFFFF_FFF0;
  localparam logic [31:0] E_305  = 32'hFFFF_F305;
  localparam logic [31:0] E_ONE  = 32'hFFFF_FFF1;
  localparam logic [31:0] E_42   = 32'hFFFF_FF42;
  localparam logic [31:0] E_7    = 32'hFFFF_FFF7;
`else
  localparam logic [31:0] E_ZERO = 32'h0000_0000;
  localparam logic [31:0] E_305  = 32'h0000_0305;
  localparam logic [31:0] E_ONE  = 32'h0000_0001;
  localparam logic [31:0] E_42   = 32'h0000_0042;
  localparam logic [31:0] E_7    = 32'h0000_0007;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, then wait for done_o; returns edges from acceptance to done.
  task automatic apply(input logic is_char, input logic [26:0] val, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("ready_before_req", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_char  = is_char;
    in_value = val;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!done_o && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int done_at;
    logic [31:0] got;
    logic busy_ready;

    vecs[0] = '{1'b0, 27'd12_345_678,  32'h1234_5678, 2'd0, 28};
    vecs[1] = '{1'b0, 27'd99_999_999,  32'h9999_9999, 2'd0, 28};
    vecs[2] = '{1'b0, 27'd0,           E_ZERO,        2'd0, 28};
    vecs[3] = '{1'b0, 27'd305,         E_305,         2'd0, 28};
    vecs[4] = '{1'b0, 27'd100_000_000, 32'hEEEE_EEEE, 2'd0, 0};
    vecs[5] = '{1'b1, 27'd3,           32'h0000_0003, 2'd1, 0};
    vecs[6] = '{1'b0, 27'h7FF_FFFF,    32'hEEEE_EEEE, 2'd0, 0};
    vecs[7] = '{1'b1, 27'h7FF_FFF5,    32'h0000_0005, 2'd1, 0};
    vecs[8] = '{1'b0, 27'd1,           E_ONE,         2'd0, 28};
    vecs[9] = '{1'b0, 27'd10_000_000,  32'h1000_0000, 2'd0, 28};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_char  = 1'b0;
    in_value = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_data",  seg_data_o,        32'hFFFF_FFFF);
    chk("reset_mode",  32'(seg_mode_o),   32'd0);
    chk("reset_ready", 32'(in_ready),     32'd1);
    chk("reset_done",  32'(done_o),       32'd0);

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].is_char, vecs[i].val, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_data", i), seg_data_o, vecs[i].exp_data);
      chk($sformatf("v%0d_mode", i), 32'(seg_mode_o), 32'(vecs[i].exp_mode));
      chk($sformatf("v%0d_ready_at_done", i), 32'(in_ready), 32'd1);
      tick();
      chk($sformatf("v%0d_done_single", i), 32'(done_o), 32'd0);
    end

    // Overflow then character on consecutive edges
    in_valid = 1'b1;
    in_char  = 1'b0;
    in_value = 27'd100_000_000;
    tick();
    chk("b2b_ovf_data", seg_data_o, 32'hEEEE_EEEE);
    chk("b2b_ovf_mode", 32'(seg_mode_o), 32'd0);
    chk("b2b_ovf_done", 32'(done_o), 32'd1);
    in_char  = 1'b1;
    in_value = 27'd3;
    tick();
    in_valid = 1'b0;
    chk("b2b_chr_data", seg_data_o, 32'h0000_0003);
    chk("b2b_chr_mode", 32'(seg_mode_o), 32'd1);
    chk("b2b_chr_done", 32'(done_o), 32'd1);
    tick();

    // Request held with a changed value while busy
    in_valid = 1'b1;
    in_char  = 1'b0;
    in_value = 27'd42;
    tick();
    in_value   = 27'd12_345;
    ndone      = 0;
    done_at    = -1;
    got        = '0;
    busy_ready = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 5) busy_ready = in_ready;
      if (done_o) begin
        ndone++;
        if (done_at < 0) begin
          done_at = n;
          got     = seg_data_o;
        end
        in_valid = 1'b0;
      end
    end
    chk("hold_busy_ready", 32'(busy_ready), 32'd0);
    chk("hold_done_count", 32'(ndone), 32'd1);
    chk("hold_done_edge", 32'(done_at), 32'd28);
    chk("hold_data", got, E_42);

    // Reset mid-conversion
    in_valid = 1'b1;
    in_char  = 1'b0;
    in_value = 27'd87_654_321;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    chk("abort_data",  seg_data_o,      32'hFFFF_FFFF);
    chk("abort_mode",  32'(seg_mode_o), 32'd0);
    chk("abort_done",  32'(done_o),     32'd0);
    chk("abort_ready", 32'(in_ready),   32'd1);
    rst   = 1'b0;
    ndone = 0;
    for (int n = 0; n < 35; n++) begin
      tick();
      if (done_o) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    apply(1'b0, 27'd7, lat);
    chk("after_abort_latency", 32'(lat), 32'd28);
    chk("after_abort_data", seg_data_o, E_7);
    chk("after_abort_mode", 32'(seg_mode_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
